// File: rtl/uart_tx_if.sv
// Byte handshake between the status-byte producers and the UART transmitter.
// A byte transfers on a rising clk edge where tx_valid and tx_ready are both 1; tx_data is sampled only then.
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: latches one byte per handshake and shifts it out LSB first.
// Every output, including the FSM state exposed on 'state', is a direct flop output.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       tx_done,
    output logic [1:0] state
);

    localparam int             CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          baud_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        baud_wrap = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                // ready_q is 0 on the first cycle out of reset, so nothing is accepted until it rises
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (bus.tx_valid && ready_q) begin
                    shift_d = bus.tx_data;
                    ready_d = 1'b0;
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end

            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            STOP: begin
                // Completion edge: back to IDLE with ready and the done pulse raised together
                if (baud_wrap) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign tx_done      = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance with one stop bit, one with two, both at 4 clocks per bit.
// Expected line waveforms come from a slot-based frame model and a byte scoreboard.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       tx0, tx1;
    logic       done0, done1;
    logic [1:0] state0, state1;

    int checks;
    int errors;

    logic [7:0] exp_q[$];

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus0),
        .tx      (tx0),
        .tx_done (done0),
        .state   (state0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus1),
        .tx      (tx1),
        .tx_done (done1),
        .state   (state1)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         exp_len;
    } vec_t;

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        if (sel == 1) begin
            bus1.tx_valid = v;
            bus1.tx_data  = d;
        end else begin
            bus0.tx_valid = v;
            bus0.tx_data  = d;
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 1) ? tx1 : tx0;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? done1 : done0;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? bus1.tx_ready : bus0.tx_ready;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 1) ? bus1.tx_valid : bus0.tx_valid;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: line level for cycle n of a frame carrying byte b
    function automatic logic model_bit(input logic [7:0] b, input int n);
        int slot;
        slot = n / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    task automatic wait_ready(input int sel);
        int n;
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("ready_wait", 64'(get_ready(sel)), 64'd1);
    endtask

    task automatic send(input int sel, input logic [7:0] b, input logic hold);
        wait_ready(sel);
        set_in(sel, 1'b1, b);
        step();
        chk("accept_ready_low", 64'(get_ready(sel)), 64'd0);
        chk("start_low", 64'(get_tx(sel)), 64'd0);
        if (!hold) set_in(sel, 1'b0, 8'($urandom));
    endtask

    task automatic capture(input int sel, input int poke_at, input logic [7:0] poke_data,
                           input logic poke_pulse, output logic [127:0] wave, output int len);
        len  = 0;
        wave = '0;
        while (get_done(sel) !== 1'b1 && len < 120) begin
            wave[len] = get_tx(sel);
            if (len == poke_at)
                set_in(sel, poke_pulse ? 1'b1 : get_valid(sel), poke_data);
            else if (poke_pulse && len == poke_at + 1)
                set_in(sel, 1'b0, poke_data);
            len++;
            step();
        end
        chk("done_seen", 64'(get_done(sel)), 64'd1);
    endtask

    // Scoreboard: compare captured frame against the model and the expected byte queue
    task automatic check_frame(input logic [127:0] wave, input int len, input int exp_len);
        logic [7:0] exp_b;
        logic [7:0] dec;
        int         mism;
        chk("frame_len", 64'(len), 64'(exp_len));
        if (exp_q.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'(exp_q.size() + 1));
            exp_b = 8'h00;
        end else begin
            exp_b = exp_q.pop_front();
        end
        for (int i = 0; i < 8; i++) dec[i] = wave[(i + 1) * CPB + CPB / 2];
        mism = 0;
        for (int n = 0; n < exp_len; n++)
            if (wave[n] !== model_bit(exp_b, n)) mism++;
        chk("frame_byte", 64'(dec), 64'(exp_b));
        chk("frame_wave", 64'(mism), 64'd0);
    endtask

    task automatic finish_frame(input int sel);
        chk("ready_at_done", 64'(get_ready(sel)), 64'd1);
        chk("idle_at_done", 64'(get_tx(sel)), 64'd1);
        step();
        chk("done_pulse_width", 64'(get_done(sel)), 64'd0);
    endtask

    initial begin
        vec_t          vecs[6];
        logic [127:0]  wave;
        int            len, len1;
        int            zeros, dones, sel;
        logic [7:0]    b;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);

        vecs[0] = '{sel: 0, data: 8'h44, exp_len: 40};
        vecs[1] = '{sel: 0, data: 8'h01, exp_len: 40};
        vecs[2] = '{sel: 0, data: 8'h80, exp_len: 40};
        vecs[3] = '{sel: 1, data: 8'h00, exp_len: 44};
        vecs[4] = '{sel: 1, data: 8'hFF, exp_len: 44};
        vecs[5] = '{sel: 1, data: 8'h5A, exp_len: 44};

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_tx0", 64'(tx0), 64'd1);
            chk("rst_ready0", 64'(bus0.tx_ready), 64'd0);
            chk("rst_done0", 64'(done0), 64'd0);
            chk("rst_tx1", 64'(tx1), 64'd1);
            chk("rst_ready1", 64'(bus1.tx_ready), 64'd0);
        end
        reset = 1'b0;
        step();
        chk("ready0_after_release", 64'(bus0.tx_ready), 64'd1);
        chk("ready1_after_release", 64'(bus1.tx_ready), 64'd1);
        chk("tx0_idle_after_release", 64'(tx0), 64'd1);

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].data);
            send(vecs[v].sel, vecs[v].data, 1'b0);
            capture(vecs[v].sel, -1, 8'h00, 1'b0, wave, len);
            check_frame(wave, len, vecs[v].exp_len);
            finish_frame(vecs[v].sel);
        end

        // Held valid: data changes mid-frame, second frame follows after one idle cycle
        exp_q.push_back(8'h44);
        send(0, 8'h44, 1'b1);
        capture(0, 10, 8'h00, 1'b0, wave, len1);
        check_frame(wave, len1, 40);
        chk("held_idle_tx", 64'(tx0), 64'd1);
        chk("held_ready_at_done", 64'(bus0.tx_ready), 64'd1);
        exp_q.push_back(8'h00);
        step();
        chk("held_restart_tx", 64'(tx0), 64'd0);
        chk("held_restart_ready", 64'(bus0.tx_ready), 64'd0);
        chk("held_done_cleared", 64'(done0), 64'd0);
        chk("held_frame_spacing", 64'(len1 + 1), 64'd41);
        set_in(0, 1'b0, 8'h00);
        capture(0, -1, 8'h00, 1'b0, wave, len);
        check_frame(wave, len, 40);
        finish_frame(0);

        // Busy ignore: a pulse with 0xFF during a frame must not be queued
        exp_q.push_back(8'h44);
        send(0, 8'h44, 1'b0);
        capture(0, 12, 8'hFF, 1'b1, wave, len);
        check_frame(wave, len, 40);
        finish_frame(0);
        zeros = 0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            if (tx0 === 1'b0) zeros++;
            if (done0 === 1'b1) dones++;
            step();
        end
        chk("busy_no_extra_frame", 64'(zeros), 64'd0);
        chk("busy_no_extra_done", 64'(dones), 64'd0);

        // Reset during data bit 3, then a clean 0xA5
        send(0, 8'h44, 1'b0);
        dones = 0;
        for (int i = 0; i < 17; i++) begin
            if (done0 === 1'b1) dones++;
            step();
        end
        reset = 1'b1;
        step();
        chk("abort_tx", 64'(tx0), 64'd1);
        chk("abort_ready", 64'(bus0.tx_ready), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        step();
        step();
        reset = 1'b0;
        step();
        if (done0 === 1'b1) dones++;
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_ready_resumes", 64'(bus0.tx_ready), 64'd1);
        exp_q.push_back(8'hA5);
        send(0, 8'hA5, 1'b0);
        capture(0, -1, 8'h00, 1'b0, wave, len);
        check_frame(wave, len, 40);
        finish_frame(0);

        // Randomized frames on either instance
        for (int r = 0; r < 12; r++) begin
            sel = $urandom_range(0, 1);
            b   = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send(sel, b, 1'b0);
            capture(sel, -1, 8'h00, 1'b0, wave, len);
            check_frame(wave, len, (sel == 1) ? 11 * CPB : 10 * CPB);
            finish_frame(sel);
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
